// File: rtl/control_fsm_mc.sv
// Multi-cycle processor main control FSM; optional ILLEGAL_TRAP_EN sends illegal opcodes to a sticky Trap state.
// Latency: one state per clock; outputs are combinational from state and inputs.
// Backpressure: Mem_ready low holds Fetch, lw2 and sw.
module control_fsm_mc #(
    parameter int OPW    = 7,
    parameter int ALUOPW = 4,
    parameter int CNTW   = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [OPW-1:0]    input_control,
    input  logic              Mem_ready,
    output logic              output_control_Branch,
    output logic              output_control_IoD,
    output logic              output_control_IRWrite,
    output logic              output_control_Mem2Reg,
    output logic              output_control_MemR,
    output logic              output_control_MemW,
    output logic              output_control_PCSrc,
    output logic              output_control_PCWrite,
    output logic              output_control_RegWrite,
    output logic [1:0]        output_control_ALUSrcA,
    output logic [1:0]        output_control_ALUSrcB,
    output logic [1:0]        output_control_BranchType,
    output logic [ALUOPW-1:0] output_control_ALUOp,
    output logic [3:0]        output_control_current_state,
    output logic [3:0]        output_control_next_state,
    output logic              output_control_Halted,
    output logic [CNTW-1:0]   output_control_retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_RTYPE    = 4'd2,
        S_RITYPE   = 4'd3,
        S_RTYPEEND = 4'd4,
        S_LW1      = 4'd5,
        S_LW2      = 4'd6,
        S_SW       = 4'd7,
        S_JALR     = 4'd8,
        S_BRANCH   = 4'd9,
        S_BRANCH2  = 4'd10,
        S_JAL      = 4'd11,
`ifdef ILLEGAL_TRAP_EN
        S_TRAP     = 4'd14,
`endif
        S_HALT     = 4'd13
    } state_t;

    localparam logic [ALUOPW-1:0] ALU_ADD = '0;
    localparam logic [ALUOPW-1:0] ALU_SUB = ALUOPW'(1);

    state_t            r_state;
    state_t            w_next;
    logic [CNTW-1:0]   r_retired;
    logic [2:0]        w_class;
    logic [3:0]        w_func;
    logic              w_retire;

    assign w_class = input_control[OPW-1 -: 3];
    assign w_func  = input_control[3:0];

    always_comb begin
        w_next                    = r_state;
        output_control_Branch     = 1'b0;
        output_control_IoD        = 1'b0;
        output_control_IRWrite    = 1'b0;
        output_control_Mem2Reg    = 1'b0;
        output_control_MemR       = 1'b0;
        output_control_MemW       = 1'b0;
        output_control_PCSrc      = 1'b0;
        output_control_PCWrite    = 1'b0;
        output_control_RegWrite   = 1'b0;
        output_control_ALUSrcA    = 2'b00;
        output_control_ALUSrcB    = 2'b00;
        output_control_BranchType = 2'b00;
        output_control_ALUOp      = ALU_ADD;
        output_control_Halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                output_control_MemR    = 1'b1;
                output_control_ALUSrcB = 2'b01;
                output_control_IRWrite = Mem_ready;
                output_control_PCWrite = Mem_ready;
                w_next = Mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                output_control_ALUSrcB = 2'b10;
                case (w_class)
                    3'b001:  w_next = S_RTYPE;
                    3'b010:  w_next = S_RITYPE;
                    3'b011:  w_next = S_LW1;
                    3'b100:  w_next = S_SW;
                    3'b101:  w_next = S_BRANCH;
                    3'b110:  w_next = S_JAL;
                    3'b111:  w_next = S_JALR;
`ifdef ILLEGAL_TRAP_EN
                    default: w_next = (w_func == 4'd0) ? S_HALT : S_TRAP;
`else
                    default: w_next = (w_func == 4'd0) ? S_HALT : S_FETCH;
`endif
                endcase
            end
            S_RTYPE: begin
                output_control_ALUSrcA = 2'b01;
                output_control_ALUOp   = ALUOPW'(w_func);
                w_next = S_RTYPEEND;
            end
            S_RITYPE: begin
                output_control_ALUSrcA = 2'b01;
                output_control_ALUSrcB = 2'b10;
                output_control_ALUOp   = ALUOPW'(w_func);
                w_next = S_RTYPEEND;
            end
            S_RTYPEEND: begin
                output_control_RegWrite = 1'b1;
                w_next = S_FETCH;
            end
            S_LW1: begin
                output_control_ALUSrcA = 2'b01;
                output_control_ALUSrcB = 2'b10;
                w_next = S_LW2;
            end
            S_LW2: begin
                output_control_MemR     = 1'b1;
                output_control_IoD      = 1'b1;
                output_control_Mem2Reg  = 1'b1;
                output_control_RegWrite = Mem_ready;
                w_next = Mem_ready ? S_FETCH : S_LW2;
            end
            S_SW: begin
                output_control_ALUSrcA = 2'b01;
                output_control_ALUSrcB = 2'b10;
                output_control_IoD     = 1'b1;
                output_control_MemW    = 1'b1;
                w_next = Mem_ready ? S_FETCH : S_SW;
            end
            S_BRANCH: begin
                output_control_ALUSrcA    = 2'b01;
                output_control_ALUOp      = ALU_SUB;
                output_control_Branch     = 1'b1;
                output_control_BranchType = w_func[1:0];
                w_next = S_BRANCH2;
            end
            // PC write here is qualified by ALU flags inside the datapath
            S_BRANCH2: begin
                output_control_Branch     = 1'b1;
                output_control_PCSrc      = 1'b1;
                output_control_BranchType = w_func[1:0];
                w_next = S_FETCH;
            end
            S_JAL: begin
                output_control_PCSrc    = 1'b1;
                output_control_PCWrite  = 1'b1;
                output_control_RegWrite = 1'b1;
                w_next = S_FETCH;
            end
            S_JALR: begin
                output_control_ALUSrcA  = 2'b01;
                output_control_ALUSrcB  = 2'b10;
                output_control_PCWrite  = 1'b1;
                output_control_RegWrite = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT: begin
                output_control_Halted = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                output_control_Halted = 1'b1;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    assign w_retire = (r_state != S_FETCH) && (w_next == S_FETCH);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + CNTW'(1);
        end
    end

    assign output_control_current_state = r_state;
    assign output_control_next_state    = w_next;
    assign output_control_retired       = r_retired;

endmodule

// File: doc/control_fsm_mc.md
Name: control_fsm_mc

Overview:
- Parametrised successor to the multi-cycle processor's main control FSM.
- Decodes the instruction word held in IR and sequences Fetch/Decode/Execute/Memory/Writeback.
- Adds memory wait-state handshakes, a Halt state, a retired-instruction counter, and parametrised opcode and ALUOp widths.
- Sits between the IR and the datapath muxes, register file, PC and memory enables.

Parameters:
OPW, 7, instruction control-field width; must be >= 7. class = input_control[OPW-1 -: 3], func = input_control[3:0].
ALUOPW, 4, output_control_ALUOp width; must be >= 4. func is zero-extended into it.
CNTW, 16, width of the retired-instruction counter.

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
input_control  in  OPW  control field from IR; stable from Decode until return to Fetch
Mem_ready  in  1  memory handshake; 1 = access completes this cycle
output_control_Branch / _IoD / _IRWrite / _Mem2Reg / _MemR / _MemW / _PCSrc / _PCWrite / _RegWrite  out  1 each  datapath strobes
output_control_ALUSrcA / _ALUSrcB / _BranchType  out  2 each  mux selects / branch condition
output_control_ALUOp  out  ALUOPW  ALU function
output_control_current_state / _next_state  out  4  state codes
output_control_Halted  out  1  1 while in Halt
output_control_retired  out  CNTW  retired-instruction count

Behaviour:
- State codes: Fetch=0, Decode=1, RType=2, RIType=3, RTypeEnd=4, lw1=5, lw2=6, sw=7, jalr=8, branch=9, branch2=10, jal=11, Halt=13, Trap=14 (Trap only with the optional feature).
- Reset low: state=Fetch and retired=0, asynchronously; takes effect mid-instruction too.
  - Outputs are combinational from state plus inputs, so during reset they show the Fetch values.
- next_state is combinational; state <= next_state on each rising edge.
- All strobes not listed for a state are 0. Selects and ALUOp default to 0 (ADD=0, SUB=1).
- Fetch: MemR=1, IoD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=ADD.
  - IRWrite=PCWrite=Mem_ready.
  - Next = Decode if Mem_ready, else Fetch (wait state; no write strobes).
- Decode: ALUSrcA=00, ALUSrcB=10, ADD. Next by class:
  - 001 RType; 010 RIType; 011 lw1; 100 sw; 101 branch; 110 jal; 111 jalr.
  - 000 with func=0 → Halt; 000 with func≠0 → Fetch (illegal opcode treated as NOP; retires).
- RType: ALUSrcA=01, ALUSrcB=00, ALUOp=func → RTypeEnd.
- RIType: ALUSrcA=01, ALUSrcB=10, ALUOp=func → RTypeEnd.
- RTypeEnd: RegWrite=1, Mem2Reg=0 → Fetch.
- lw1: ALUSrcA=01, ALUSrcB=10, ADD → lw2.
- lw2: MemR=1, IoD=1, Mem2Reg=1, RegWrite=Mem_ready. Stays in lw2 until Mem_ready, then → Fetch.
- sw: ALUSrcA=01, ALUSrcB=10, ADD, IoD=1, MemW=1. Holds until Mem_ready, then → Fetch.
- branch: ALUSrcA=01, ALUSrcB=00, SUB, Branch=1, BranchType=func[1:0] → branch2.
- branch2: Branch=1, PCSrc=1, BranchType=func[1:0] → Fetch. The datapath qualifies the PC write with the ALU flags.
- jal: PCSrc=1, PCWrite=1, RegWrite=1, Mem2Reg=0 → Fetch.
- jalr: ALUSrcA=01, ALUSrcB=10, ADD, PCSrc=0, PCWrite=1, RegWrite=1 → Fetch.
- Halt: all strobes 0, Halted=1. Stays until reset.
  - Mem_ready is ignored.
  - Entering Halt does not increment retired.
- Retired counter: +1 on every edge where state≠Fetch and next_state=Fetch. Wraps modulo 2^CNTW.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - class 000 with func≠0 in Decode → Trap.
  - Trap: all strobes 0, Halted=1, no retire; stays in Trap until reset.
  - current_state reads 14.
- Undefined: Trap does not exist; illegal opcodes behave as NOP → Fetch and retire.

Test Plan:
- Reset low mid-lw2, then release → state=0 immediately while low. retired=0. First post-reset cycle shows MemR=1, ALUSrcB=01, next_state=1 when Mem_ready=1.
- input_control=7'b0010000 (and), Mem_ready=1 → states 0,1,2,4,0. In state 2: ALUSrcA=01, ALUSrcB=00, ALUOp=0. In state 4: RegWrite=1. retired 0→1.
- lw with Mem_ready low 3 cycles in Fetch and 2 cycles in lw2 → Fetch repeats 3 cycles with IRWrite=0, then Decode. lw2 lasts 3 cycles with RegWrite=1 only in the last. Total 9 cycles, retired+1.
- Branch 7'b1010010 → branch: ALUOp=1, BranchType=10, Branch=1. branch2: PCSrc=1. Then Fetch.
- 7'b0000000 → Halt after Decode: Halted=1 for 20 cycles with toggling Mem_ready. retired unchanged.
- 7'b0000101: with ILLEGAL_TRAP_EN → state 14, Halted=1, no retire. Without it → Fetch, retired+1.
